// File: rtl/player_pkg.sv
// Shared types and default geometry for the player controller
// and the draw_player sprite stage.
package player_pkg;

  localparam int POS_W = 12;
  localparam int VY_W  = 8;

  localparam int X_INIT   = 400;
  localparam int X_MIN    = 0;
  localparam int X_MAX    = 768;
  localparam int Y_GROUND = 600;
  localparam int Y_MIN    = 0;
  localparam int STEP_X   = 4;
  localparam int JUMP_V0  = 20;
  localparam int GRAVITY  = 1;
  localparam int VY_MAX   = 16;

  typedef enum logic [1:0] {
    GROUND,
    RISE,
    FALL
  } player_state_t;

endpackage

// File: rtl/vga_if.sv
// VGA timing stream as seen by per-frame game logic.
// Only the vertical blanking flag is carried here.
interface vga_if;

  logic vblnk;

  modport out (output vblnk);
  modport in  (input  vblnk);

endinterface

// File: rtl/frame_tick.sv
// One-cycle pulse at the rising edge of vertical blanking.
// Reusable by any logic that advances once per frame.
module frame_tick (
  input  logic clk,
  input  logic rst,
  input  logic vblnk,
  output logic tick
);

  logic vblnk_d;

  always_ff @(posedge clk) begin
    if (rst) vblnk_d <= 1'b0;
    else     vblnk_d <= vblnk;
  end

  assign tick = vblnk & ~vblnk_d;

endmodule

// File: rtl/player_ctl.sv
// Per-frame player motion: clamped horizontal stepping and a
// ground/rise/fall jump machine with integer gravity.
module player_ctl #(
  parameter int X_INIT   = player_pkg::X_INIT,
  parameter int X_MIN    = player_pkg::X_MIN,
  parameter int X_MAX    = player_pkg::X_MAX,
  parameter int Y_GROUND = player_pkg::Y_GROUND,
  parameter int Y_MIN    = player_pkg::Y_MIN,
  parameter int STEP_X   = player_pkg::STEP_X,
  parameter int JUMP_V0  = player_pkg::JUMP_V0,
  parameter int GRAVITY  = player_pkg::GRAVITY,
  parameter int VY_MAX   = player_pkg::VY_MAX
) (
  input  logic                         clk,
  input  logic                         rst,
  vga_if.in                            vga_in,
  input  logic                         move_left,
  input  logic                         move_right,
  input  logic                         jump,
  output logic [player_pkg::POS_W-1:0] xpos,
  output logic [player_pkg::POS_W-1:0] ypos,
  output logic                         facing,
  output logic                         airborne
);

  import player_pkg::*;

  localparam int EW = POS_W + 1;

  logic            tick;
  logic            jump_req;
  logic            jump_eff;
  player_state_t   st, st_n;
  logic [VY_W-1:0] vy, vy_n, vy_f;
  logic [POS_W-1:0] x_n, y_n;
  logic            f_n;

  logic signed [EW-1:0] xl;
  logic        [EW-1:0] xr;
  logic signed [EW-1:0] yr;
  logic        [EW-1:0] yf;
  logic        [VY_W:0] vf;

  frame_tick u_tick (
    .clk   (clk),
    .rst   (rst),
    .vblnk (vga_in.vblnk),
    .tick  (tick)
  );

  // A jump seen on the tick cycle itself still counts for that tick
  assign jump_eff = jump_req | jump;

  always_ff @(posedge clk) begin
    if (rst)       jump_req <= 1'b0;
    else if (tick) jump_req <= 1'b0;
    else if (jump) jump_req <= 1'b1;
  end

  always_comb begin
    x_n = xpos;
    f_n = facing;
    xl  = $signed({1'b0, xpos}) - $signed(EW'(STEP_X));
    xr  = {1'b0, xpos} + EW'(STEP_X);
    unique case (1'b1)
      move_left & ~move_right: begin
        f_n = 1'b1;
        if (xl < $signed(EW'(X_MIN))) x_n = POS_W'(X_MIN);
        else                          x_n = xl[POS_W-1:0];
      end
      move_right & ~move_left: begin
        f_n = 1'b0;
        if (xr > EW'(X_MAX)) x_n = POS_W'(X_MAX);
        else                 x_n = xr[POS_W-1:0];
      end
      default: ;
    endcase
  end

  always_comb begin
    st_n = st;
    vy_n = vy;
    y_n  = ypos;
    yr   = $signed({1'b0, ypos}) - $signed(EW'(vy));
    vf   = {1'b0, vy} + (VY_W+1)'(GRAVITY);
    vy_f = (vf > (VY_W+1)'(VY_MAX)) ? VY_W'(VY_MAX) : vf[VY_W-1:0];
    yf   = {1'b0, ypos} + EW'(vy_f);
    unique case (st)
      GROUND: begin
        if (jump_eff) begin
          vy_n = VY_W'(JUMP_V0);
          st_n = RISE;
        end
      end
      RISE: begin
        if (yr < $signed(EW'(Y_MIN))) begin
          y_n  = POS_W'(Y_MIN);
          vy_n = '0;
          st_n = FALL;
        end else begin
          y_n  = yr[POS_W-1:0];
          vy_n = vy - VY_W'(GRAVITY);
          if (vy_n == '0) st_n = FALL;
        end
      end
      FALL: begin
        if (yf >= EW'(Y_GROUND)) begin
          y_n  = POS_W'(Y_GROUND);
          vy_n = '0;
          st_n = GROUND;
        end else begin
          y_n  = yf[POS_W-1:0];
          vy_n = vy_f;
        end
      end
      default: st_n = GROUND;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      xpos     <= POS_W'(X_INIT);
      ypos     <= POS_W'(Y_GROUND);
      facing   <= 1'b0;
      airborne <= 1'b0;
      vy       <= '0;
      st       <= GROUND;
    end else if (tick) begin
      xpos     <= x_n;
      ypos     <= y_n;
      facing   <= f_n;
      airborne <= (st_n != GROUND);
      vy       <= vy_n;
      st       <= st_n;
    end
  end

endmodule

// File: doc/player_ctl.md
# player_ctl

Per-frame player motion controller that drives the `draw_player` datapath with the sprite position. It samples user movement requests, detects start of vertical blanking on the VGA stream, and updates the registered `xpos`/`ypos` once per frame. Horizontal moves are clamped; a ground/rise/fall state machine implements jumping with integer gravity. Sits between the input decoder (keyboard/buttons) and the draw pipeline.

## Interface
- X_INIT, 400: horizontal position after reset.
- X_MIN, 0: left clamp.
- X_MAX, 768: right clamp.
- Y_GROUND, 600: vertical rest position (floor).
- Y_MIN, 0: ceiling clamp.
- STEP_X, 4: horizontal pixels per frame.
- JUMP_V0, 20: initial upward speed, px/frame.
- GRAVITY, 1: speed change per frame.
- VY_MAX, 16: terminal fall speed.
- clk  in  1  pixel clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- vga_in  vga_if.in  —  timing stream; only `vblnk` is used.
- move_left  in  1  level; held = move left.
- move_right  in  1  level; held = move right.
- jump  in  1  pulse or level; requests a jump.
- xpos  out  12  sprite x, unsigned.
- ypos  out  12  sprite y, unsigned.
- facing  out  1  0 = right, 1 = left.
- airborne  out  1  high in RISE or FALL.

## Operation
- **Frame tick:** `vblnk_d` registers `vga_in.vblnk`; `tick = vblnk & ~vblnk_d`. This gives exactly one cycle per frame.
- **Jump request:** `jump_req` is a sticky flag. It is set on any cycle with `jump` high and cleared on every tick. A `jump` arriving on the tick cycle itself counts for that tick.
- **Horizontal step (on tick):**
  - `move_left` only: x = max(x − STEP_X, X_MIN), facing = 1.
  - `move_right` only: x = min(x + STEP_X, X_MAX), facing = 0.
  - Both or neither: hold x and facing.
  - Compute in 13 bits so underflow below X_MIN is detected.
- **Vertical FSM (on tick only):**
  - GROUND: if `jump_req`, set vy = JUMP_V0 and go to RISE; y is unchanged this tick. Otherwise hold.
  - RISE: compute y' = y − vy in 13-bit signed.
    - If y' < Y_MIN: y = Y_MIN, vy = 0, go to FALL.
    - Else: y = y', vy = vy − GRAVITY; go to FALL when the new vy is 0.
  - FALL: vy = min(vy + GRAVITY, VY_MAX).
    - If y + vy ≥ Y_GROUND: y = Y_GROUND, vy = 0, go to GROUND.
    - Else: y = y + vy.
- `jump_req` in RISE or FALL is discarded; jumps are never buffered across frames.
- Horizontal and vertical updates occur on the same tick and are independent.
- vy is 8-bit unsigned; its direction is implied by the state.
- Parameter legality: JUMP_V0 must be a multiple of GRAVITY and ≤ 255.

## Timing
- Reset values:
  - xpos = X_INIT, ypos = Y_GROUND, facing = 0, airborne = 0.
  - State GROUND; vy = 0; `jump_req` = 0; `vblnk_d` = 0.
- Latency: in the cycle where tick is high, registers update at the closing edge. New position is visible the following cycle. Since this is inside blanking, no tearing occurs.
- Between ticks all outputs are stable.
- `airborne` is registered from the next state, so it is aligned with ypos.
- Reset mid-jump: on the next edge, all state returns to the reset values.
- A `vblnk` already high when reset deasserts produces a tick on the first cycle after reset (because `vblnk_d` = 0). This is accepted.
- No handshake: `xpos`/`ypos` are sampled freely by the draw stage.

## Structure
- Shared package `player_pkg` holds:
  - enum `player_state_t` {GROUND, RISE, FALL};
  - `POS_W` = 12, `VY_W` = 8;
  - default constants X_INIT, Y_GROUND, etc., reused by `draw_player` for sprite bounds.
- Natural sub-module: `frame_tick`, the vblnk rising-edge detector with a registered delay and synchronous reset. It is reusable by other per-frame game logic.
- Remaining logic stays flat in `player_ctl` (two always_ff blocks plus next-state comb).

## Test plan
- **Reset:** assert `rst` 3 cycles with `vblnk` toggling → xpos = 400, ypos = 600, facing = 0, airborne = 0 throughout, with no update on ticks during reset.
- **Right clamp:** start at x = 760, hold `move_right` for 3 frames → xpos 764, 768, 768; facing = 0. Holding both buttons for 2 frames leaves x at 768.
- **Left clamp:** x = 6, hold `move_left` → xpos 2, 0, 0; facing = 1, set on the first tick.
- **Full jump (defaults):** pulse `jump` for 1 cycle mid-frame.
  - Tick 1: ypos 600, airborne = 1.
  - 20 RISE ticks: peak ypos = 390.
  - 21 FALL ticks: last tick lands at 600, airborne = 0.
  - Total 42 ticks.
- **Jump while airborne:** pulse `jump` during RISE → no effect on the trajectory, and no second jump after landing.
- **Ceiling (Y_GROUND = 100, JUMP_V0 = 20):** ypos 100, 80, 61, 43, 26, 10, then 0 (clamped), then FALL with vy = 1 → 1.
